// File: rtl/seq_rest_div_pkg.sv
// Shared types and reset values for the sequential restoring divider.
package seq_rest_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam state_t RST_STATE = IDLE;
    localparam logic   RST_FLAG  = 1'b0;

endpackage

// File: rtl/seq_rest_div_if.sv
// Request/result bundle for seq_rest_div; the sgn signal exists only
// when SEQ_REST_DIV_SIGNED_EN is defined.
interface seq_rest_div_if #(
    parameter int W = 8
);
    logic         start;
    logic [W-1:0] x;
    logic [W-1:0] y;
`ifdef SEQ_REST_DIV_SIGNED_EN
    logic         sgn;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;

`ifdef SEQ_REST_DIV_SIGNED_EN
    modport master (output start, x, y, sgn, input busy, done, q, r, dbz);
    modport slave  (input start, x, y, sgn, output busy, done, q, r, dbz);
`else
    modport master (output start, x, y, input busy, done, q, r, dbz);
    modport slave  (input start, x, y, output busy, done, q, r, dbz);
`endif
endinterface

// File: rtl/seq_rest_div_step.sv
// One restoring-division iteration: shift {A,Q} left, trial-subtract M,
// restore on a negative result.
module rest_div_step #(
    parameter int W = 8
) (
    input  logic [W:0]   a,
    input  logic [W-1:0] q,
    input  logic [W:0]   m,
    output logic [W:0]   a_nx,
    output logic [W-1:0] q_nx
);
    logic [W:0] a_sh;
    logic [W:0] diff;
    // A stays below M after every restore, so its top bit is always zero
    logic       unused_a_msb;

    assign unused_a_msb = a[W];

    always_comb begin
        a_sh = {a[W-1:0], q[W-1]};
        diff = a_sh - m;
        if (diff[W]) begin
            a_nx = a_sh;
            q_nx = {q[W-2:0], 1'b0};
        end else begin
            a_nx = diff;
            q_nx = {q[W-2:0], 1'b1};
        end
    end
endmodule

// File: rtl/seq_rest_div.sv
// Sequential restoring divider, one quotient bit per clock.
// Define SEQ_REST_DIV_SIGNED_EN to add two's-complement division via bus.sgn.
module seq_rest_div
    import seq_rest_div_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst,
    seq_rest_div_if.slave bus
);
    state_t        state_q, state_d;
    logic [W:0]    a_q, m_q, a_nx;
    logic [W-1:0]  qr_q, q_nx;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  q_q, r_q;
    logic          dbz_q;
    logic          qneg_q, rneg_q;
    logic          x_neg, y_neg;
    logic [W-1:0]  x_mag, y_mag;
    logic          accept, last_iter;

    assign accept    = bus.start && (state_q != RUN);
    assign last_iter = (cnt_q == CW'(W - 1));

    rest_div_step #(.W(W)) u_step (
        .a    (a_q),
        .q    (qr_q),
        .m    (m_q),
        .a_nx (a_nx),
        .q_nx (q_nx)
    );

    // Signed mode divides magnitudes; signs are reapplied when results land
    always_comb begin
        x_neg = 1'b0;
        y_neg = 1'b0;
        x_mag = bus.x;
        y_mag = bus.y;
`ifdef SEQ_REST_DIV_SIGNED_EN
        if (bus.sgn) begin
            x_neg = bus.x[W-1];
            y_neg = bus.y[W-1];
        end
        if (x_neg) x_mag = -bus.x;
        if (y_neg) y_mag = -bus.y;
`endif
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (last_iter) state_d = DONE;
            end
            default: begin
                if (bus.start) state_d = (bus.y == '0) ? DONE : RUN;
                else           state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RST_STATE;
            a_q     <= '0;
            m_q     <= '0;
            qr_q    <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= RST_FLAG;
            qneg_q  <= RST_FLAG;
            rneg_q  <= RST_FLAG;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q    <= '0;
                qr_q   <= x_mag;
                m_q    <= {1'b0, y_mag};
                cnt_q  <= '0;
                qneg_q <= x_neg ^ y_neg;
                rneg_q <= x_neg;
                if (bus.y == '0) begin
                    q_q   <= '1;
                    r_q   <= bus.x;
                    dbz_q <= 1'b1;
                end
            end else if (state_q == RUN) begin
                a_q   <= a_nx;
                qr_q  <= q_nx;
                cnt_q <= cnt_q + CW'(1);
                if (last_iter) begin
                    q_q   <= qneg_q ? -q_nx : q_nx;
                    r_q   <= rneg_q ? -a_nx[W-1:0] : a_nx[W-1:0];
                    dbz_q <= 1'b0;
                end
            end
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.q    = q_q;
    assign bus.r    = r_q;
    assign bus.dbz  = dbz_q;
endmodule

// File: tb/tb_seq_rest_div.sv
// Scoreboard bench for seq_rest_div: directed cases plus random traffic
// checked against an arithmetic reference model.
module tb_seq_rest_div;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int unsigned  acc;
        int unsigned  cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned cyc = 0;
    int unsigned next_free = 0;
    int          compared = 0;
    int          mismatched = 0;
    exp_t        sb[$];
    logic [W-1:0] last_q = '0;
    logic [W-1:0] last_r = '0;
    logic         last_dbz = 1'b0;

    seq_rest_div_if #(.W(W)) bus ();

    seq_rest_div #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference: plain integer division; signed uses truncating / and %
    function automatic void ref_div(input logic [W-1:0] x, input logic [W-1:0] y, input bit s,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic dbz);
        int xi, yi;
        dbz = 1'b0;
        if (y == '0) begin
            q = '1;
            r = x;
            dbz = 1'b1;
        end else if (s) begin
            xi = $signed(x);
            yi = $signed(y);
            q = W'(xi / yi);
            r = W'(xi % yi);
        end else begin
            q = x / y;
            r = x % y;
        end
    endfunction

    // Called at a falling edge; a request is taken at the next rising edge
    // only if the previous result is already on the outputs.
    task automatic drive(input bit st, input logic [W-1:0] x, input logic [W-1:0] y, input bit s);
        exp_t e;
        bus.start = st;
        bus.x = x;
        bus.y = y;
`ifdef SEQ_REST_DIV_SIGNED_EN
        bus.sgn = s;
`endif
        if (st && cyc >= next_free) begin
            ref_div(x, y, s, e.q, e.r, e.dbz);
            e.acc = cyc + 1;
            e.cyc = cyc + 1 + ((y == '0) ? 0 : W);
            next_free = e.cyc;
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic wait_free();
        while (cyc < next_free) drive(1'b0, '0, '0, 1'b0);
        drive(1'b0, '0, '0, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        bus.start = 1'b0;
        sb.delete();
        last_q = '0;
        last_r = '0;
        last_dbz = 1'b0;
        #1;
        check("rst_busy", W'(bus.busy), '0);
        check("rst_done", W'(bus.done), '0);
        check("rst_q", bus.q, '0);
        check("rst_r", bus.r, '0);
        check("rst_dbz", W'(bus.dbz), '0);
        @(negedge clk);
        rst = 1'b0;
        next_free = cyc;
    endtask

    always @(negedge clk) begin
        exp_t e;
        bit exp_busy;
        if (!rst) begin
            exp_busy = (sb.size() > 0) && (sb[0].acc <= cyc) && (cyc < sb[0].cyc);
            check("busy", W'(bus.busy), W'(exp_busy));
            if (bus.done) begin
                if (sb.size() == 0) begin
                    check("spurious_done", W'(bus.done), '0);
                end else begin
                    e = sb.pop_front();
                    check("done_cycle", W'(cyc), W'(e.cyc));
                    check("q", bus.q, e.q);
                    check("r", bus.r, e.r);
                    check("dbz", W'(bus.dbz), W'(e.dbz));
                    last_q = e.q;
                    last_r = e.r;
                    last_dbz = e.dbz;
                end
            end else begin
                check("hold_q", bus.q, last_q);
                check("hold_r", bus.r, last_r);
                check("hold_dbz", W'(bus.dbz), W'(last_dbz));
            end
        end
    end

    initial begin
        logic [W-1:0] rx, ry;
        bit rs;
        bus.start = 1'b0;
        bus.x = '0;
        bus.y = '0;
`ifdef SEQ_REST_DIV_SIGNED_EN
        bus.sgn = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("init_busy", W'(bus.busy), '0);
        check("init_done", W'(bus.done), '0);
        check("init_q", bus.q, '0);
        check("init_r", bus.r, '0);
        check("init_dbz", W'(bus.dbz), '0);
        rst = 1'b0;
        next_free = cyc;

        drive(1'b1, 8'd200, 8'd7, 1'b0);
        wait_free();
        drive(1'b1, 8'd5, 8'd0, 1'b0);
        wait_free();

        // second request lands mid-run and must be ignored
        drive(1'b1, 8'd255, 8'd1, 1'b0);
        repeat (3) drive(1'b0, '0, '0, 1'b0);
        drive(1'b1, 8'd9, 8'd3, 1'b0);
        wait_free();

        drive(1'b1, 8'd100, 8'd9, 1'b0);
        repeat (3) drive(1'b0, '0, '0, 1'b0);
        do_reset();
        drive(1'b1, 8'd100, 8'd9, 1'b0);
        wait_free();

        drive(1'b1, 8'd17, 8'd5, 1'b0);
        while (cyc < next_free) drive(1'b1, 8'd17, 8'd5, 1'b0);
        drive(1'b1, 8'd0, 8'd3, 1'b0);
        wait_free();

        drive(1'b1, 8'd0, 8'd0, 1'b0);
        drive(1'b1, 8'd123, 8'd255, 1'b0);
        wait_free();

`ifdef SEQ_REST_DIV_SIGNED_EN
        drive(1'b1, 8'hF9, 8'd2, 1'b1);
        wait_free();
        drive(1'b1, 8'hF9, 8'd2, 1'b0);
        wait_free();
        drive(1'b1, 8'h80, 8'hFF, 1'b1);
        wait_free();
        drive(1'b1, 8'hF9, 8'd0, 1'b1);
        wait_free();
`endif

        for (int i = 0; i < 600; i++) begin
            rx = W'($urandom);
            case ($urandom_range(0, 7))
                0:       ry = '0;
                1:       ry = W'($urandom_range(1, 3));
                default: ry = W'($urandom);
            endcase
`ifdef SEQ_REST_DIV_SIGNED_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            drive(($urandom_range(0, 2) == 0), rx, ry, rs);
            if (i == 300) do_reset();
        end

        wait_free();
        repeat (2) drive(1'b0, '0, '0, 1'b0);
        check("scoreboard_empty", W'(sb.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/seq_rest_div.md
SEQ_REST_DIV -- requirements
Module: seq_rest_div

Interface
REQ-001 Parameter W, default 8, operand/result width in bits (W >= 2).
REQ-002 Parameter CW, default $clog2(W+1), iteration counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request; sampled on clk rising edge.
REQ-006 x  input  W  dividend; sampled only on the accepting edge.
REQ-007 y  input  W  divisor; sampled only on the accepting edge.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse; q, r and dbz are valid.
REQ-010 q  output  W  quotient, registered.
REQ-011 r  output  W  remainder, registered.
REQ-012 dbz  output  1  divide-by-zero flag, registered.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE.
REQ-014 Start SHALL be accepted only in IDLE or DONE; start in RUN SHALL be ignored, with no effect on the operation in flight.
REQ-015 Accept with y != 0: load A=0 (W+1 bits), Q=x, M={0,y}, counter=0; next state RUN; busy=1 from the next cycle.
REQ-016 RUN SHALL perform one restoring iteration per clock: {A,Q} shifted left 1; A=A-M; if A[W]=1, Q[0]=0 and A restored (+M), else Q[0]=1.
REQ-017 After exactly W iterations, the state SHALL be DONE, with q=Q, r=A[W-1:0] and dbz=0; done first high W cycles after the accepting edge.
REQ-018 Accept with y == 0: skip RUN; next state DONE, with q=all ones, r=x and dbz=1 (latency 1 cycle).
REQ-019 DONE SHALL last exactly one cycle: done=1 and busy=0; next state is IDLE, or RUN/DONE if start is asserted in that cycle (back-to-back accept).
REQ-020 q, r and dbz SHALL change only on entry to DONE and SHALL hold until the next DONE entry or reset.
REQ-021 x=0 SHALL yield q=0, r=0; y=1 SHALL yield q=x, r=0; invariant x = q*y + r with r < y whenever dbz=0.

Reset
REQ-022 On rst=1, regardless of clk: state=IDLE; busy, done, dbz=0; q, r=0; internal A, Q, M and counter cleared.
REQ-023 Reset during RUN SHALL abort the operation with no done pulse; start SHALL be accepted on the first edge after rst deasserts.

Configuration
REQ-024 Macro SEQ_REST_DIV_SIGNED_EN defined: add input port sgn (1 bit, sampled on accept); when sgn=1, x and y are two's complement, their magnitudes are divided, q takes sign(x) XOR sign(y), and r takes sign(x); latency is unchanged.
REQ-025 Signed DBZ SHALL give q=all ones, r=x and dbz=1.
REQ-026 Macro undefined: sgn port absent; unsigned-only behaviour per REQ-015..021.

Structure
REQ-027 Package seq_rest_div_pkg SHALL hold the state typedef (IDLE/RUN/DONE) and the reset-value constants.
REQ-028 Sub-module rest_div_step (combinational, parameter W) SHALL implement one REQ-016 iteration: inputs A, Q, M; outputs next A and next Q; instantiated once.

Verification
REQ-029 W=8, x=200, y=7, start 1 cycle -> done exactly 8 cycles later; q=28, r=4, dbz=0.
REQ-030 W=8, x=5, y=0 -> done 1 cycle later; q=255, r=5, dbz=1.
REQ-031 W=8, x=255, y=1, then start with x=9, y=3 pulsed mid-RUN -> q=255, r=0; the second request is ignored and only one done pulse occurs.
REQ-032 rst pulsed 4 cycles into x=100, y=9 -> all outputs 0 immediately and no done; a new x=100, y=9 then gives q=11, r=1.
REQ-033 Back-to-back: start held high through DONE with x=17, y=5 then x=0, y=3 -> q=3, r=2 followed by q=0, r=0; second done exactly 8 cycles after the first.
REQ-034 SEQ_REST_DIV_SIGNED_EN, sgn=1, x=-7 (0xF9), y=2 -> q=-3 (0xFD), r=-1 (0xFF); sgn=0 with the same bits -> q=124, r=1.
